// File: rtl/is_uart_rx.sv
// is_uart_rx - UART receiver feeding the UART controller FSM.
//
// Synchronises rx_i, finds the start bit, samples 8 data bits LSB-first, an
// optional parity bit and the stop bit at mid-bit points, then presents the
// character as {frame_err, parity_err, data[7:0]} with a one-cycle strobe.
//
// Optional feature: define IS_UART_RX_PARITY_EN for an 11-bit frame with a
// parity bit checked per PARITY_ODD. Without it the frame is 10 bits and
// rx_data_r_o[8] is always 0.
//
// Ports:
//   clk_i         system clock
//   rstn_i        asynchronous active-low reset
//   rx_i          asynchronous serial line, idle high
//   rx_data_r_o   {frame_err, parity_err, data}, held until the next character
//   rx_data_en_o  one-cycle strobe marking rx_data_r_o valid
//   busy_o        high whenever the receiver is not idle
module is_uart_rx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       rx_i,
    output logic [9:0] rx_data_r_o,
    output logic       rx_data_en_o,
    output logic       busy_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    // The sample happens on the cycle the counter is already 0, hence the -1.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    if (CLKS_PER_BIT < 4 || PARITY_ODD > 1) begin : g_param_check
        $error("is_uart_rx: CLKS_PER_BIT must be >= 4 and PARITY_ODD 0 or 1");
    end

    logic [1:0]       sync_q;
    logic             rxs;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [9:0]       data_q, data_d;
    logic             en_q, en_d;
    logic             tick;
    logic             par_bit;

`ifdef IS_UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic par_err_q, par_err_d;
    assign par_bit = par_err_q;
`else
    assign par_bit = 1'b0;
`endif

    assign rxs  = sync_q[1];
    assign tick = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        en_d    = 1'b0;
`ifdef IS_UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            S_START: begin
                if (tick) begin
                    cnt_d   = FULL_LOAD;
                    bit_d   = 3'd0;
                    // A high line at mid start bit is a glitch: drop it silently.
                    state_d = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_d   = FULL_LOAD;
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef IS_UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef IS_UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    cnt_d     = FULL_LOAD;
                    par_err_d = ((^shift_q) ^ rxs) != PAR_ODD;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    en_d    = 1'b1;
                    data_d  = {~rxs, par_bit, shift_q};
                    // Leaving for IDLE here lets a start edge in the second
                    // half of the stop bit be caught.
                    state_d = rxs ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q  <= 2'b11;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            en_q    <= en_d;
        end
    end

`ifdef IS_UART_RX_PARITY_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`endif

    assign rx_data_r_o  = data_q;
    assign rx_data_en_o = en_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_is_uart_rx.sv
// Directed testbench for is_uart_rx at 16 clocks per bit.
module tb_is_uart_rx;

    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int          CPB      = 16;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       rx_i = 1'b1;
    logic [9:0] rx_data_r_o;
    logic       rx_data_en_o;
    logic       busy_o;

    int tests_run = 0;
    int tests_failed = 0;

    is_uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .PARITY_ODD(0)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .rx_i        (rx_i),
        .rx_data_r_o (rx_data_r_o),
        .rx_data_en_o(rx_data_en_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    int         strobe_cnt = 0;
    int         wide_cnt = 0;
    int         chg_cnt = 0;
    logic [9:0] last_data = '0;
    logic [9:0] held = '0;
    int         last_cyc = 0;
    logic       en_prev = 1'b0;
    logic [9:0] strobe_data[$];
    int         strobe_cyc[$];

    always @(negedge clk_i) begin
        if (!rstn_i) begin
            held = '0;
        end else if (rx_data_en_o) begin
            if (en_prev) wide_cnt++;
            strobe_cnt++;
            last_data = rx_data_r_o;
            last_cyc  = cyc;
            held      = rx_data_r_o;
            strobe_data.push_back(rx_data_r_o);
            strobe_cyc.push_back(cyc);
        end else if (rx_data_r_o !== held) begin
            chg_cnt++;
            held = rx_data_r_o;
        end
        en_prev = rx_data_en_o;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        tick(CPB);
    endtask

    // 8-bit frame; with parity enabled a correct even parity bit is inserted.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef IS_UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop);
    endtask

    task automatic test_reset;
        rstn_i = 1'b0;
        tick(3);
        tests_run++;
        if (rx_data_r_o !== 10'h000) begin
            tests_failed++;
            $display("FAIL reset_data: got %h want 000", rx_data_r_o);
        end
        tests_run++;
        if (rx_data_en_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_en: got %b want 0", rx_data_en_o);
        end
        tests_run++;
        if (busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b want 0", busy_o);
        end
        rstn_i = 1'b1;
        tick(10);
        tests_run++;
        if (busy_o !== 1'b0 || strobe_cnt !== 0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: busy %b strobes %0d want 0 0", busy_o, strobe_cnt);
        end
    endtask

    task automatic test_basic;
        int base;
        int t0;
        base = strobe_cnt;
        t0   = cyc;
        send_frame(8'h41, 1'b1);
        rx_i = 1'b1;
        tick(20);
        tests_run++;
        if (strobe_cnt - base !== 1) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d want 1", strobe_cnt - base);
        end
        tests_run++;
        if (last_data !== 10'h041) begin
            tests_failed++;
            $display("FAIL basic_data: got %h want 041", last_data);
        end
        // rx_i edge -> rxs low after 2 edges, seen by the FSM on the 3rd;
        // stop sample 8 + 9*16 later; strobe visible right after that edge.
        tests_run++;
        if (last_cyc - t0 !== 155) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d want 155", last_cyc - t0);
        end
        tests_run++;
        if (wide_cnt !== 0) begin
            tests_failed++;
            $display("FAIL basic_strobe_width: got %0d wide strobes want 0", wide_cnt);
        end
    endtask

    task automatic test_patterns;
        logic [7:0] pats[3];
        pats[0] = 8'h00;
        pats[1] = 8'hFF;
        pats[2] = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            send_frame(pats[i], 1'b1);
            rx_i = 1'b1;
            tick(10);
            tests_run++;
            if (last_data !== {2'b00, pats[i]}) begin
                tests_failed++;
                $display("FAIL pattern_%0d: got %h want %h", i, last_data, {2'b00, pats[i]});
            end
        end
    endtask

`ifdef IS_UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(1'b1);
    endtask

    task automatic test_parity;
        send_frame_par(8'h37, 1'b1);
        tick(10);
        tests_run++;
        if (last_data !== 10'h037) begin
            tests_failed++;
            $display("FAIL parity_good: got %h want 037", last_data);
        end
        send_frame_par(8'h37, 1'b0);
        tick(10);
        tests_run++;
        if (last_data !== 10'h137) begin
            tests_failed++;
            $display("FAIL parity_bad: got %h want 137", last_data);
        end
    endtask
`endif

    task automatic test_break;
        int base;
        base = strobe_cnt;
        send_frame(8'h0D, 1'b0);
        rx_i = 1'b0;
        tick(40 * CPB);
        tests_run++;
        if (strobe_cnt - base !== 1) begin
            tests_failed++;
            $display("FAIL break_count: got %0d want 1", strobe_cnt - base);
        end
        tests_run++;
        if (last_data !== 10'h20D) begin
            tests_failed++;
            $display("FAIL break_data: got %h want 20D", last_data);
        end
        tests_run++;
        if (busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL break_busy_held: got %b want 1", busy_o);
        end
        rx_i = 1'b1;
        tick(6);
        tests_run++;
        if (busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL break_release: got busy %b want 0", busy_o);
        end
        tick(20);
    endtask

    task automatic test_glitch;
        int base;
        base = strobe_cnt;
        rx_i = 1'b0;
        tick(5);
        rx_i = 1'b1;
        tests_run++;
        if (busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch_busy_rise: got %b want 1", busy_o);
        end
        tick(7);
        tests_run++;
        if (busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_busy_fall: got %b want 0", busy_o);
        end
        tick(40);
        tests_run++;
        if (strobe_cnt !== base) begin
            tests_failed++;
            $display("FAIL glitch_strobe: got %0d strobes want 0", strobe_cnt - base);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] exp[4];
        exp[0] = 10'h033;
        exp[1] = 10'h046;
        exp[2] = 10'h00D;
        exp[3] = 10'h00A;
        strobe_data.delete();
        strobe_cyc.delete();
        for (int i = 0; i < 4; i++) send_frame(exp[i][7:0], 1'b1);
        rx_i = 1'b1;
        tick(30);
        tests_run++;
        if (strobe_data.size() !== 4) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d want 4", strobe_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (strobe_data[i] !== exp[i]) begin
                    tests_failed++;
                    $display("FAIL b2b_data_%0d: got %h want %h", i, strobe_data[i], exp[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                tests_run++;
                if (strobe_cyc[i] - strobe_cyc[i-1] !== 160) begin
                    tests_failed++;
                    $display("FAIL b2b_spacing_%0d: got %0d want 160", i,
                             strobe_cyc[i] - strobe_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_abort;
        int         base;
        logic [7:0] d;
        d    = 8'h13;
        base = strobe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx_i = d[4];
        tick(8);
        rstn_i = 1'b0;
        tick(2);
        tests_run++;
        if (busy_o !== 1'b0 || rx_data_r_o !== 10'h000) begin
            tests_failed++;
            $display("FAIL abort_reset_state: busy %b data %h want 0 000", busy_o, rx_data_r_o);
        end
        rstn_i = 1'b1;
        rx_i   = 1'b1;
        tick(40);
        tests_run++;
        if (strobe_cnt !== base) begin
            tests_failed++;
            $display("FAIL abort_no_strobe: got %0d strobes want 0", strobe_cnt - base);
        end
        send_frame(8'h5A, 1'b1);
        tick(20);
        tests_run++;
        if (strobe_cnt - base !== 1) begin
            tests_failed++;
            $display("FAIL abort_next_count: got %0d want 1", strobe_cnt - base);
        end
        tests_run++;
        if (last_data !== 10'h05A) begin
            tests_failed++;
            $display("FAIL abort_next_data: got %h want 05A", last_data);
        end
    endtask

    task automatic test_final;
        tests_run++;
        if (wide_cnt !== 0) begin
            tests_failed++;
            $display("FAIL strobe_width: got %0d wide strobes want 0", wide_cnt);
        end
        tests_run++;
        if (chg_cnt !== 0) begin
            tests_failed++;
            $display("FAIL data_hold: got %0d changes without strobe want 0", chg_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
`ifdef IS_UART_RX_PARITY_EN
        test_parity();
`endif
        test_break();
        test_glitch();
        test_back_to_back();
        test_reset_abort();
        test_final();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
